// File: rtl/bcd_seven_segment_scanner.sv
// Time-multiplexed BCD to seven-segment display driver with a load-captured shadow word.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks digits above the most significant nonzero nibble).
module bcd_seven_segment_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  err
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] nibble_at(input logic [4*DIGITS-1:0] word,
                                             input logic [IW-1:0]       idx);
        nibble_at = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            nibble_at = (idx == IW'(i)) ? word[4*i +: 4] : nibble_at;
        end
    endfunction

    function automatic logic any_invalid(input logic [4*DIGITS-1:0] word);
        any_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_invalid = any_invalid | (word[4*i +: 4] > 4'd9);
        end
    endfunction

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    function automatic logic leading_blank(input logic [4*DIGITS-1:0] word,
                                           input logic [IW-1:0]       idx);
        logic upper_nonzero;
        upper_nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            upper_nonzero = upper_nonzero | ((IW'(i) >= idx) && (word[4*i +: 4] != 4'd0));
        end
        leading_blank = (idx != {IW{1'b0}}) && !upper_nonzero;
    endfunction

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [PW-1:0]       presc_q,  presc_d;
    logic [IW-1:0]       index_q,  index_d;
    logic [6:0]          seg_q,    seg_d;
    logic [DIGITS-1:0]   an_q,     an_d;
    logic                err_q,    err_d;
    logic                tick_s;

    // Next-state for the shadow word, refresh prescaler, scan index and output pipeline.
    always_comb begin
        shadow_d = shadow_q;
        presc_d  = presc_q;
        index_d  = index_q;
        an_d     = '0;

        tick_s = (presc_q == PRESC_LAST);

        if (load) begin
            shadow_d = bcd_in;
        end else begin
            shadow_d = shadow_q;
        end

        if (tick_s) begin
            presc_d = '0;
            if (index_q == INDEX_LAST) begin
                index_d = '0;
            end else begin
                index_d = index_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
            index_d = index_q;
        end

        // Outputs are built from the pre-edge index so an and seg always describe the same digit.
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = (index_q == IW'(i));
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (leading_blank(shadow_q, index_q)) begin
            seg_d = 7'h00;
        end else begin
            seg_d = decode(nibble_at(shadow_q, index_q));
        end
`else
        seg_d = decode(nibble_at(shadow_q, index_q));
`endif
        err_d = any_invalid(shadow_q);
    end

    // State and registered outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            presc_q  <= '0;
            index_q  <= '0;
            seg_q    <= 7'h00;
            an_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            index_q  <= index_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            err_q    <= err_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule
